versatile_fifo_sc_ctrl: RTL

VERSATILE_FIFO_SC_CTRL -- requirements
Module: versatile_fifo_sc_ctrl

---
 rtl/versatile_fifo_sc_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/versatile_fifo_sc_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM with registered read.
// Head word is prefetched onto ram_q_b; rd_valid counts toward occupancy.
module versatile_fifo_sc_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_overflow,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic [DATA_WIDTH-1:0] ram_d_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [CW-1:0]         ram_cnt;
  logic [CW-1:0]         count_next;
  logic                  wr_acc;
  logic                  rd_take;
  logic                  fetch;

  // Handshake decode; reset suppresses both RAM-side actions.
  always_comb begin
    wr_acc     = wr_en & ~full & ~rst;
    rd_take    = rd_valid & rd_ready;
    fetch      = ~rst & (ram_cnt != '0) & (~rd_valid | rd_ready);
    count_next = count + CW'(wr_acc) - CW'(rd_take);
  end

  // Without a fetch, re-read the head slot so ram_q_b stays stable.
  always_comb begin
    ram_we_a  = wr_acc;
    ram_adr_a = wp;
    ram_d_a   = wr_data;
    ram_adr_b = fetch ? rp : rp - ADDR_WIDTH'(1);
    ram_we_b  = 1'b0;
    ram_d_b   = '0;
    rd_data   = ram_q_b;
    empty     = ~rd_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      ram_cnt     <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      full        <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_acc) wp <= wp + ADDR_WIDTH'(1);
      if (fetch)  rp <= rp + ADDR_WIDTH'(1);
      ram_cnt <= ram_cnt + CW'(wr_acc) - CW'(fetch);
      if (fetch)        rd_valid <= 1'b1;
      else if (rd_take) rd_valid <= 1'b0;
      count       <= count_next;
      full        <= (count_next == CW'(DEPTH));
      wr_overflow <= wr_en & full;
    end
  end

endmodule
